mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Parametrised multicycle multiply/divide unit that produces HI/LO results for the datapath's HI and LO registers.
- Replaces the fixed 32-bit separate multiply and divide controllers with one iterative engine.
- Adds a start/busy/done handshake, a signed/unsigned mode and a divide-by-zero flag for the control unit's exception path.

Parameters:
- WIDTH, 32, operand width in bits; hi and lo are each WIDTH bits. Legal range 4..64.
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- op  input  1  operation select: 0 = multiply, 1 = divide.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned operands.
- a  input  WIDTH  multiplicand or dividend; sampled when start is accepted.
- b  input  WIDTH  multiplier or divisor; sampled when start is accepted.
- busy  output  1  high while an operation is in progress (CALC, FIX).
- done  output  1  one-cycle pulse; hi/lo/div_zero are valid while it is high.
- div_zero  output  1  last accepted operation was a divide with b==0.
- hi  output  WIDTH  multiply: upper product half; divide: remainder.
- lo  output  WIDTH  multiply: lower product half; divide: quotient.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, div_zero=0; hi=0, lo=0; counter and internal registers cleared. An operation in flight is abandoned with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE / DONE with start=1 ("accept", edge k):
  - Latch magnitudes of a and b; |x| applies only when is_signed=1 and the MSB is 1.
  - Latch result-sign flags; clear div_zero; set counter=WIDTH; go to CALC.
- Accept of a divide with b==0:
  - Go directly to DONE at edge k with div_zero=1; hi and lo keep their previous values.
  - done is high for the cycle after edge k.
- CALC:
  - One radix-2 iteration per edge, counter decrements by 1.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division on a 2*WIDTH remainder/quotient register.
  - When the counter reaches 0 (after edge k+WIDTH), go to FIX.
- FIX (edge k+WIDTH+1): apply sign correction, write hi/lo, go to DONE.
  - Multiply: the product is negated when the operand signs differ (signed mode only).
  - Divide: the quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
- DONE: done=1 for exactly one cycle.
  - Next state is CALC if start=1 (back-to-back accept), else IDLE.
- Latency: done is high in the cycle following edge k+WIDTH+1, i.e. WIDTH+2 edges after accept.
- busy: 1 in CALC and FIX, 0 in IDLE and DONE.
- start while busy is ignored; a, b, op and is_signed may change freely while busy.
- hi/lo hold their value until the next FIX; they are valid at done and afterwards.
- Signed overflow, -2^(WIDTH-1) / -1: lo = 2^(WIDTH-1) bit pattern, hi = 0, no flag.
- Multiply never overflows, since the full 2*WIDTH product is returned.

Test Plan:
- Reset mid-operation: pull reset low 5 edges after accepting mul 7*6 -> busy, done and hi/lo = 0 immediately; no done pulse follows the release of reset.
- Signed multiply, WIDTH=32: a=0xFFFFFFFD (-3), b=7 -> done exactly 34 edges after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); busy high for 33 cycles.
- Unsigned multiply: a=b=0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide: a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Signed overflow divide: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Divide by zero, then back-to-back: previous hi/lo=5/9, then div with b=0 -> done 1 edge after accept, div_zero=1, hi/lo remain 5/9.
  - Hold start=1 through DONE with mul 3*4 -> accepted, div_zero clears, lo=12.
  - A start pulse during CALC is ignored.
  - Repeat the multiply case with WIDTH=8: a=0xFD, b=7 -> hi=0xFF, lo=0xEB, done after 10 edges.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide engine producing HI/LO.
//   clock, reset (async, active-low)
//   start, op (0 mul / 1 div), is_signed, a, b : request and operands
//   busy, done, div_zero                      : handshake and exception flag
//   hi, lo                                    : product halves or remainder/quotient
`timescale 1ns/1ps
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   bm_q, bm_d;
  logic               op_q, op_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Operand magnitudes; negation only applies to negative signed operands
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // Shift-add step: conditionally add multiplicand to upper half, shift right
  logic [WIDTH:0]  mul_sum;
  logic [W2-1:0]   mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? bm_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Restoring step: shift left one, subtract divisor when it fits, shift in quotient bit
  logic [WIDTH:0]  div_top;
  logic [WIDTH:0]  div_diff;
  logic            div_ge;
  logic [W2-1:0]   div_next;

  always_comb begin
    div_top  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_top - {1'b0, bm_q};
    div_ge   = (div_top >= {1'b0, bm_q});
    div_next = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                      : {acc_q[W2-2:0], 1'b0};
  end

  // Sign correction applied in FIX
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    bm_d      = bm_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d      = op;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = 1'b0;
          if (op && (b == '0)) begin
            // Divide by zero skips the engine; hi/lo keep their old values
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            bm_d    = b_mag;
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_CALC;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d = op_q ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      bm_q      <= '0;
      op_q      <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      bm_q      <= bm_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit at WIDTH=32 and WIDTH=8
// against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_mult_div_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic        s32, op32, sg32, busy32, done32, dz32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        s8, op8, sg8, busy8, done8, dz8;
  logic [7:0]  a8, b8, hi8, lo8;

  mult_div_unit #(.WIDTH(32)) u_dut32 (
    .clock(clock), .reset(reset), .start(s32), .op(op32), .is_signed(sg32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .div_zero(dz32),
    .hi(hi32), .lo(lo32));

  mult_div_unit #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .start(s8), .op(op8), .is_signed(sg8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .div_zero(dz8),
    .hi(hi8), .lo(lo8));

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] ph32 = '0, pl32 = '0, ph8 = '0, pl8 = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on sign-extended operands
  function automatic void ref_op(input int w, input bit op, input bit sg,
                                 input logic [63:0] ai, input logic [63:0] bi,
                                 input logic [63:0] phi, input logic [63:0] plo,
                                 output logic [63:0] hi, output logic [63:0] lo,
                                 output bit dz);
    logic [63:0] mask;
    logic [63:0] av, bv;
    longint sa, sb, p, q, r;
    mask = (64'd1 << w) - 64'd1;
    av = ai & mask;
    bv = bi & mask;
    sa = (sg && av[w-1]) ? longint'(av | ~mask) : longint'(av);
    sb = (sg && bv[w-1]) ? longint'(bv | ~mask) : longint'(bv);
    dz = 1'b0;
    if (!op) begin
      p  = sa * sb;
      hi = 64'(p >>> w) & mask;
      lo = 64'(p) & mask;
    end else if (bv == 64'd0) begin
      dz = 1'b1;
      hi = phi;
      lo = plo;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = 64'(r) & mask;
      lo = 64'(q) & mask;
    end
  endfunction

  task automatic drive(input bit w8, input bit st, input bit op, input bit sg,
                       input logic [63:0] a, input logic [63:0] b);
    if (w8) begin
      s8 = st; op8 = op; sg8 = sg; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      s32 = st; op32 = op; sg32 = sg; a32 = a[31:0]; b32 = b[31:0];
    end
  endtask

  function automatic logic o_busy(input bit w8); return w8 ? busy8 : busy32; endfunction
  function automatic logic o_done(input bit w8); return w8 ? done8 : done32; endfunction
  function automatic logic o_dz(input bit w8);   return w8 ? dz8 : dz32;     endfunction
  function automatic logic [63:0] o_hi(input bit w8);
    return w8 ? {56'd0, hi8} : {32'd0, hi32};
  endfunction
  function automatic logic [63:0] o_lo(input bit w8);
    return w8 ? {56'd0, lo8} : {32'd0, lo32};
  endfunction

  // Called #1 after the accept edge; counts edges (accept edge = 1) until done,
  // and fires a stray start pulse mid-calculation that must be ignored.
  task automatic wait_done(input bit w8, output int edges, output int bcyc);
    edges = 1;
    bcyc  = 0;
    while (!o_done(w8) && edges < 200) begin
      if (o_busy(w8)) bcyc++;
      if (edges == 3) drive(w8, 1'b1, 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      if (edges == 4) drive(w8, 1'b0, 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      @(posedge clock); #1;
      edges++;
    end
    if (!o_done(w8)) check("timeout_done", 64'd0, 64'd1);
  endtask

  task automatic do_op(input bit w8, input bit op, input bit sg,
                       input logic [63:0] a, input logic [63:0] b, input string tag);
    int w;
    logic [63:0] eh, el;
    bit edz;
    int edges, bc;
    w = w8 ? 8 : 32;
    ref_op(w, op, sg, a, b, w8 ? ph8 : ph32, w8 ? pl8 : pl32, eh, el, edz);
    @(negedge clock);
    drive(w8, 1'b1, op, sg, a, b);
    @(posedge clock); #1;
    drive(w8, 1'b0, 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    wait_done(w8, edges, bc);
    check({tag, ".hi"},   o_hi(w8), eh);
    check({tag, ".lo"},   o_lo(w8), el);
    check({tag, ".dz"},   64'(o_dz(w8)), 64'(edz));
    check({tag, ".lat"},  64'(edges), edz ? 64'd1 : 64'(w + 2));
    check({tag, ".busy"}, 64'(bc), edz ? 64'd0 : 64'(w + 1));
    if (w8) begin ph8 = eh; pl8 = el; end
    else begin ph32 = eh; pl32 = el; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int edges, bc, ndone;
    logic [63:0] ra, rb;
    bit w8;

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    #2;
    check("rst.busy", 64'(busy32), 64'd0);
    check("rst.done", 64'(done32), 64'd0);
    check("rst.dz",   64'(dz32),   64'd0);
    check("rst.hi",   {32'd0, hi32}, 64'd0);
    check("rst.lo",   {32'd0, lo32}, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    do_op(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFD, 64'd7, "smul32");
    do_op(1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "umul32");
    do_op(1'b0, 1'b1, 1'b1, 64'hFFFF_FFF9, 64'd2, "sdiv32");
    do_op(1'b0, 1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, "ovf32");
    do_op(1'b0, 1'b1, 1'b0, 64'd95, 64'd10, "prep");

    // Divide by zero with start held high into a back-to-back multiply
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 64'd123, 64'd0);
    @(posedge clock); #1;
    check("dz.done", 64'(done32), 64'd1);
    check("dz.flag", 64'(dz32),   64'd1);
    check("dz.hi",   {32'd0, hi32}, 64'd5);
    check("dz.lo",   {32'd0, lo32}, 64'd9);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 64'd3, 64'd4);
    @(posedge clock); #1;
    check("b2b.dz",   64'(dz32),   64'd0);
    check("b2b.busy", 64'(busy32), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    wait_done(1'b0, edges, bc);
    check("b2b.lo",  {32'd0, lo32}, 64'd12);
    check("b2b.hi",  {32'd0, hi32}, 64'd0);
    check("b2b.lat", 64'(edges), 64'd34);
    ph32 = 64'd0; pl32 = 64'd12;

    // Reset five edges into a multiply
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 64'd7, 64'd6);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("rmid.busy", 64'(busy32), 64'd0);
    check("rmid.done", 64'(done32), 64'd0);
    check("rmid.hi",   {32'd0, hi32}, 64'd0);
    check("rmid.lo",   {32'd0, lo32}, 64'd0);
    #2;
    reset = 1'b1;
    ndone = 0;
    repeat (50) begin
      @(posedge clock); #1;
      if (done32) ndone++;
    end
    check("rmid.nodone", 64'(ndone), 64'd0);
    ph32 = '0; pl32 = '0; ph8 = '0; pl8 = '0;

    do_op(1'b1, 1'b0, 1'b1, 64'hFD, 64'd7, "smul8");

    for (int i = 0; i < 60; i++) begin
      w8 = (i >= 30);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rb = 64'd0;
      if ($urandom_range(0, 7) == 0) begin
        ra = w8 ? 64'h80 : 64'h8000_0000;
        rb = '1;
      end
      do_op(w8, 1'($urandom), 1'($urandom), ra, rb, w8 ? "rnd8" : "rnd32");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
